// File: rtl/peak_pkg.sv
// Shared types and widths for the window peak tracker and its comparator.
package peak_pkg;

  localparam int DW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/comparator.sv
// 4-bit unsigned magnitude comparator: exactly one of less/equal/greater is high.
module comparator
  import peak_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          less,
  output logic          equal,
  output logic          greater
);

  assign less    = (a < b);
  assign equal   = (a == b);
  assign greater = (a > b);

endmodule

// File: rtl/window_peak_tracker.sv
// Tracks max, min and max-tie count over WINDOW accepted samples, then presents the
// result until it is taken downstream.
module window_peak_tracker
  import peak_pkg::*;
#(
  parameter int WINDOW = 8,
  parameter int TW     = $clog2(WINDOW + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_max,
  output logic [DW-1:0] res_min,
  output logic [TW-1:0] res_ties,
  output logic          new_max,
  output logic          new_min
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // Producers hold valid and data until the transfer; ready never depends on valid.
  localparam logic [7:0] CNT_LAST = 8'(WINDOW);

  state_t        state_q, state_d;
  logic [DW-1:0] max_q, max_d;
  logic [DW-1:0] min_q, min_d;
  logic [TW-1:0] ties_q, ties_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          new_max_q, new_max_d;
  logic          new_min_q, new_min_d;

  logic max_lt, max_eq, max_gt;
  logic min_lt, min_eq, min_gt;
  logic accept;

  comparator u_max_cmp (
    .a       (in_data),
    .b       (max_q),
    .less    (max_lt),
    .equal   (max_eq),
    .greater (max_gt)
  );

  comparator u_min_cmp (
    .a       (in_data),
    .b       (min_q),
    .less    (min_lt),
    .equal   (min_eq),
    .greater (min_gt)
  );

  assign accept = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    max_d     = max_q;
    min_d     = min_q;
    ties_d    = ties_q;
    cnt_d     = cnt_q;
    new_max_d = 1'b0;
    new_min_d = 1'b0;

    if (clear) begin
      state_d = IDLE;
      max_d   = '0;
      min_d   = '0;
      ties_d  = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            max_d     = in_data;
            min_d     = in_data;
            ties_d    = TW'(1);
            cnt_d     = 8'd1;
            new_max_d = 1'b1;
            new_min_d = 1'b1;
            state_d   = (WINDOW == 1) ? HOLD : ACC;
          end
        end
        ACC: begin
          if (accept) begin
            case ({max_gt, max_eq, max_lt})
              3'b100: begin
                max_d     = in_data;
                ties_d    = TW'(1);
                new_max_d = 1'b1;
              end
              3'b010:  ties_d = (&ties_q) ? ties_q : ties_q + TW'(1);
              default: ;
            endcase
            case ({min_gt, min_eq, min_lt})
              3'b001: begin
                min_d     = in_data;
                new_min_d = 1'b1;
              end
              default: ;
            endcase
            cnt_d = cnt_q + 8'd1;
            if (cnt_d == CNT_LAST) state_d = HOLD;
          end
        end
        HOLD: begin
          if (res_ready) begin
            state_d = IDLE;
            max_d   = '0;
            min_d   = '0;
            ties_d  = '0;
            cnt_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      max_q     <= '0;
      min_q     <= '0;
      ties_q    <= '0;
      cnt_q     <= '0;
      new_max_q <= 1'b0;
      new_min_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      max_q     <= max_d;
      min_q     <= min_d;
      ties_q    <= ties_d;
      cnt_q     <= cnt_d;
      new_max_q <= new_max_d;
      new_min_q <= new_min_d;
    end
  end

  assign in_ready  = (state_q != HOLD);
  assign res_valid = (state_q == HOLD);
  assign res_max   = max_q;
  assign res_min   = min_q;
  assign res_ties  = ties_q;
  assign new_max   = new_max_q;
  assign new_min   = new_min_q;

endmodule

// File: tb/tb_window_peak_tracker.sv
// Directed bench for window_peak_tracker: a WINDOW=3 instance and a WINDOW=1 instance.
module tb_window_peak_tracker;

  logic clk;
  logic reset;

  logic       a_clear, a_in_valid, a_in_ready, a_res_valid, a_res_ready;
  logic [3:0] a_in_data, a_res_max, a_res_min;
  logic [1:0] a_res_ties;
  logic       a_new_max, a_new_min;

  logic       b_clear, b_in_valid, b_in_ready, b_res_valid, b_res_ready;
  logic [3:0] b_in_data, b_res_max, b_res_min;
  logic [0:0] b_res_ties;
  logic       b_new_max, b_new_min;

  int n_checks;
  int n_pass;

  // Expected results packed as {max[3:0], min[3:0], ties[1:0]}
  logic [9:0] exp_q[$];

  window_peak_tracker #(.WINDOW(3)) u_w3 (
    .clk(clk), .reset(reset), .clear(a_clear),
    .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
    .res_valid(a_res_valid), .res_ready(a_res_ready),
    .res_max(a_res_max), .res_min(a_res_min), .res_ties(a_res_ties),
    .new_max(a_new_max), .new_min(a_new_min)
  );

  window_peak_tracker #(.WINDOW(1)) u_w1 (
    .clk(clk), .reset(reset), .clear(b_clear),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .res_valid(b_res_valid), .res_ready(b_res_ready),
    .res_max(b_res_max), .res_min(b_res_min), .res_ties(b_res_ties),
    .new_max(b_new_max), .new_min(b_new_min)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver: offer one sample for a single cycle and check the pulses it produced
  task automatic send(input logic [3:0] d, input logic exp_nm, input logic exp_nmin);
    a_in_valid = 1'b1;
    a_in_data  = d;
    step();
    a_in_valid = 1'b0;
    check("new_max", a_new_max, exp_nm);
    check("new_min", a_new_min, exp_nmin);
  endtask

  task automatic check_result(input logic [9:0] e);
    check("res_valid", a_res_valid, 1);
    check("in_ready_hold", a_in_ready, 0);
    check("res_max", a_res_max, e[9:6]);
    check("res_min", a_res_min, e[5:2]);
    check("res_ties", a_res_ties, e[1:0]);
  endtask

  task automatic release_result();
    a_res_ready = 1'b1;
    step();
    a_res_ready = 1'b0;
    check("res_valid_after_hs", a_res_valid, 0);
    check("in_ready_after_hs", a_in_ready, 1);
    check("res_max_zeroed", a_res_max, 0);
  endtask

  // nm/nmin bit i is the expected pulse for sample i
  task automatic run_window(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2,
                            input logic [2:0] nm, input logic [2:0] nmin,
                            input logic [9:0] res, input bit do_release);
    logic [9:0] e;
    exp_q.push_back(res);
    send(d0, nm[0], nmin[0]);
    check("in_ready_acc", a_in_ready, 1);
    check("res_valid_acc", a_res_valid, 0);
    send(d1, nm[1], nmin[1]);
    send(d2, nm[2], nmin[2]);
    e = exp_q.pop_front();
    check_result(e);
    if (do_release) release_result();
  endtask

  initial begin
    logic [9:0] e;
    n_checks = 0;
    n_pass   = 0;
    reset = 1'b1;
    a_clear = 0; a_in_valid = 0; a_in_data = 0; a_res_ready = 0;
    b_clear = 0; b_in_valid = 0; b_in_data = 0; b_res_ready = 0;
    #2;
    check("rst_in_ready", a_in_ready, 1);
    check("rst_res_valid", a_res_valid, 0);
    check("rst_res_max", a_res_max, 0);
    check("rst_res_min", a_res_min, 0);
    check("rst_res_ties", a_res_ties, 0);
    check("rst_new_max", a_new_max, 0);
    check("rst_new_min", a_new_min, 0);
    @(negedge clk);
    reset = 1'b0;
    step();

    // rising samples
    run_window(4'd10, 4'd12, 4'd15, 3'b111, 3'b001, {4'd15, 4'd10, 2'd1}, 1);
    // max revisited: two ties, new_max only on first sample
    run_window(4'd15, 4'd11, 4'd15, 3'b001, 3'b011, {4'd15, 4'd11, 2'd2}, 1);
    // all equal
    run_window(4'd10, 4'd10, 4'd10, 3'b001, 3'b001, {4'd10, 4'd10, 2'd3}, 1);

    // backpressure: result held while in_valid stays high
    run_window(4'd1, 4'd9, 4'd5, 3'b011, 3'b001, {4'd9, 4'd1, 2'd1}, 0);
    e = {4'd9, 4'd1, 2'd1};
    a_in_valid = 1'b1;
    a_in_data  = 4'd14;
    for (int i = 0; i < 5; i++) begin
      step();
      check_result(e);
      check("new_max_stall", a_new_max, 0);
    end
    a_res_ready = 1'b1;
    step();
    a_res_ready = 1'b0;
    check("bubble_res_valid", a_res_valid, 0);
    check("bubble_in_ready", a_in_ready, 1);
    check("bubble_new_max", a_new_max, 0);
    step();
    a_in_valid = 1'b0;
    check("next_first_new_max", a_new_max, 1);
    check("next_first_new_min", a_new_min, 1);
    send(4'd2, 1'b0, 1'b1);
    send(4'd14, 1'b0, 1'b0);
    check_result({4'd14, 4'd2, 2'd2});
    release_result();

    // clear mid-window, with a competing sample in the same cycle
    send(4'd12, 1'b1, 1'b1);
    send(4'd3, 1'b0, 1'b1);
    a_clear    = 1'b1;
    a_in_valid = 1'b1;
    a_in_data  = 4'd9;
    step();
    a_clear    = 1'b0;
    a_in_valid = 1'b0;
    check("clr_new_max", a_new_max, 0);
    check("clr_new_min", a_new_min, 0);
    check("clr_res_max", a_res_max, 0);
    check("clr_res_min", a_res_min, 0);
    check("clr_res_ties", a_res_ties, 0);
    check("clr_in_ready", a_in_ready, 1);
    run_window(4'd4, 4'd5, 4'd6, 3'b111, 3'b001, {4'd6, 4'd4, 2'd1}, 1);

    // asynchronous reset mid-window
    send(4'd8, 1'b1, 1'b1);
    send(4'd9, 1'b1, 1'b0);
    reset = 1'b1;
    #2;
    check("arst_new_max", a_new_max, 0);
    check("arst_in_ready", a_in_ready, 1);
    check("arst_res_max", a_res_max, 0);
    check("arst_res_min", a_res_min, 0);
    check("arst_res_ties", a_res_ties, 0);
    check("arst_res_valid", a_res_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    step();
    run_window(4'd5, 4'd2, 4'd7, 3'b101, 3'b011, {4'd7, 4'd2, 2'd1}, 1);

    // single-sample window
    b_in_valid = 1'b1;
    b_in_data  = 4'd7;
    step();
    b_in_valid = 1'b0;
    check("w1_res_valid", b_res_valid, 1);
    check("w1_in_ready", b_in_ready, 0);
    check("w1_res_max", b_res_max, 7);
    check("w1_res_min", b_res_min, 7);
    check("w1_res_ties", b_res_ties, 1);
    check("w1_new_max", b_new_max, 1);
    check("w1_new_min", b_new_min, 1);
    b_res_ready = 1'b1;
    step();
    b_res_ready = 1'b0;
    check("w1_res_valid_hs", b_res_valid, 0);
    check("w1_in_ready_hs", b_in_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
